pwm_capture: RTL and testbench

Receive-side counterpart to the PWM DAC. It takes a PWM waveform (nominal period 2^WIDTH clocks, rising edge at frame start) and recovers the WIDTH-bit duty code by counting high cycles per frame. It publishes one code per frame with a valid pulse, plus lock and period-error status. It is used for loopback verification of PWM outputs and for reading PWM-encoded sensor or control lines.

---
 rtl/pwm_capture.sv | 145 ++++++++++++++
 tb/tb_pwm_capture.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture
//   Recovers the WIDTH-bit duty code of a PWM waveform whose nominal frame is
//   2^WIDTH clocks long and starts with a rising edge. High cycles are counted
//   per frame. One code is published per frame with a single-cycle valid pulse,
//   together with lock and period-error status.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset (release synchronous to clk)
//   pwm_in      in   PWM input, asynchronous to clk
//   duty_out    out  last recovered duty code, held between updates
//   duty_valid  out  one-cycle pulse when duty_out updates
//   locked      out  last frame ended on a rising edge after exactly 2^WIDTH cycles
//   period_err  out  last rise-terminated frame had a period other than 2^WIDTH
module pwm_capture #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_out,
  output logic             duty_valid,
  output logic             locked,
  output logic             period_err
);

  localparam int CNT_W = WIDTH + 1;

  // Nominal frame length and largest representable code, both counter-wide.
  localparam logic [CNT_W-1:0] PERIOD   = {1'b1, {WIDTH{1'b0}}};
  localparam logic [CNT_W-1:0] CODE_MAX = {1'b0, {WIDTH{1'b1}}};

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  // A full frame of constant high counts 2^WIDTH, which does not fit the
  // output code; clamp it to the all-ones code.
  function automatic logic [WIDTH-1:0] sat_code(input logic [CNT_W-1:0] cnt);
    logic [WIDTH-1:0] code;
    if (cnt > CODE_MAX) begin
      code = CODE_MAX[WIDTH-1:0];
    end else begin
      code = cnt[WIDTH-1:0];
    end
    return code;
  endfunction

  logic             sync_p0;
  logic             sync_p1;
  logic             s_d_p2;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  state_t           state;

  logic             rise;
  logic             at_period;
  logic             timeout;
  logic             boundary;
  logic [WIDTH-1:0] sat;

  // Stage p0/p1: two-flop synchronizer; sync_p1 is the clean sample s.
  // Stage p2: one-cycle delay of s for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      s_d_p2  <= 1'b0;
    end else begin
      sync_p0 <= pwm_in;
      sync_p1 <= sync_p0;
      s_d_p2  <= sync_p1;
    end
  end

  // A rise together with a full count is a good frame, never a timeout.
  always_comb begin
    rise      = sync_p1 & ~s_d_p2;
    at_period = (period_cnt == PERIOD);
    timeout   = at_period & ~rise;
    boundary  = rise | at_period;
    sat       = sat_code(high_cnt);
  end

  // Frame counters. The boundary cycle itself is the first cycle of the new
  // frame, so the counters restart at 1 and at the current sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= CNT_W'(1);
      high_cnt   <= '0;
    end else if (boundary) begin
      period_cnt <= CNT_W'(1);
      high_cnt   <= CNT_W'(sync_p1);
    end else begin
      period_cnt <= period_cnt + CNT_W'(1);
      high_cnt   <= high_cnt + CNT_W'(sync_p1);
    end
  end

  // Frame state and registered outputs. IDLE means no rise has been seen
  // since reset or the last timeout, so the running frame is partial.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      duty_out   <= '0;
      duty_valid <= 1'b0;
      locked     <= 1'b0;
      period_err <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            // Partial frame: nothing published, status untouched.
            state <= MEASURE;
          end else if (timeout) begin
            duty_out   <= sat;
            duty_valid <= 1'b1;
            locked     <= 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            duty_out   <= sat;
            duty_valid <= 1'b1;
            if (at_period) begin
              locked     <= 1'b1;
              period_err <= 1'b0;
            end else begin
              locked     <= 1'b0;
              period_err <= 1'b1;
            end
          end else if (timeout) begin
            duty_out   <= sat;
            duty_valid <= 1'b1;
            locked     <= 1'b0;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture. The reference model keeps the samples of the
// current frame in a queue: frame length is the queue size, the duty code is
// the number of ones in it, clamped to the largest code.
module tb_pwm_capture;

  localparam int WIDTH = 10;
  localparam int P     = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pwm_in;
  logic [WIDTH-1:0] duty_out;
  logic             duty_valid;
  logic             locked;
  logic             period_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .duty_out  (duty_out),
    .duty_valid(duty_valid),
    .locked    (locked),
    .period_err(period_err)
  );

  // Reference model state
  bit hist[$];      // input samples still travelling through the 2-cycle lag
  bit frame_q[$];   // samples belonging to the current frame
  bit prev_s;
  bit in_frame;     // a rise has been seen since reset / last timeout
  int exp_duty;
  bit exp_valid;
  bit exp_locked;
  bit exp_perr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    frame_q.delete();
    frame_q.push_back(1'b0);
    prev_s     = 1'b0;
    in_frame   = 1'b0;
    exp_duty   = 0;
    exp_valid  = 1'b0;
    exp_locked = 1'b0;
    exp_perr   = 1'b0;
  endfunction

  function automatic int frame_code();
    int ones = 0;
    foreach (frame_q[i]) ones += int'(frame_q[i]);
    return (ones > P - 1) ? P - 1 : ones;
  endfunction

  function automatic void model_sample(input bit x);
    bit r;
    r = x & ~prev_s;
    exp_valid = 1'b0;
    if (r) begin
      if (in_frame) begin
        exp_valid  = 1'b1;
        exp_duty   = frame_code();
        exp_locked = (frame_q.size() == P);
        exp_perr   = !exp_locked;
      end
      in_frame = 1'b1;
      frame_q.delete();
      frame_q.push_back(x);
    end else if (frame_q.size() == P) begin
      exp_valid  = 1'b1;
      exp_duty   = frame_code();
      exp_locked = 1'b0;
      in_frame   = 1'b0;
      frame_q.delete();
      frame_q.push_back(x);
    end else begin
      frame_q.push_back(x);
    end
    prev_s = x;
  endfunction

  task automatic check_outputs();
    check("valid",  32'(duty_valid), 32'(exp_valid));
    check("duty",   32'(duty_out),   exp_duty);
    check("locked", 32'(locked),     32'(exp_locked));
    check("perr",   32'(period_err), 32'(exp_perr));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_duty"},   32'(duty_out),   0);
    check({tag, "_valid"},  32'(duty_valid), 0);
    check({tag, "_locked"}, 32'(locked),     0);
    check({tag, "_perr"},   32'(period_err), 0);
  endtask

  // One clock: drive, advance past the edge, update model, compare.
  task automatic step(input bit v);
    pwm_in = v;
    @(posedge clk);
    #1;
    model_sample(hist.pop_front());
    hist.push_back(v);
    check_outputs();
  endtask

  task automatic rst_tick();
    pwm_in = 1'($urandom);
    @(posedge clk);
    #1;
    check_zero("rst");
  endtask

  task automatic frame(input int per, input int hi);
    for (int i = 0; i < per; i++) step(i < hi);
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  initial begin
    int per;
    int hi;
    int code;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    repeat (5) rst_tick();
    rst_n = 1'b1;
    model_reset();

    // 50% duty at nominal period
    repeat (4) frame(P, P / 2);
    check("half_duty",   32'(duty_out),   512);
    check("half_locked", 32'(locked),     1);
    check("half_perr",   32'(period_err), 0);

    // Extremes
    repeat (3) frame(P, P - 1);
    check("hi1023_duty",   32'(duty_out), 1023);
    check("hi1023_locked", 32'(locked),   1);
    hold(1'b1, 3 * P + 10);
    check("const1_duty",   32'(duty_out), 1023);
    check("const1_locked", 32'(locked),   0);
    hold(1'b0, 3 * P + 10);
    check("const0_duty",   32'(duty_out), 0);
    check("const0_locked", 32'(locked),   0);

    // Wrong period, then recovery
    repeat (3) frame(700, 350);
    check("p700_duty",   32'(duty_out),   350);
    check("p700_perr",   32'(period_err), 1);
    check("p700_locked", 32'(locked),     0);
    repeat (3) frame(P, 100);
    check("rec_duty",   32'(duty_out),   100);
    check("rec_perr",   32'(period_err), 0);
    check("rec_locked", 32'(locked),     1);

    // Sweep from a count-up DAC: high for the first `code` counts
    for (int i = 0; i < 10; i++) begin
      code = 1023 >> i;
      repeat (3) frame(P, code);
      check("sweep_duty",   32'(duty_out), code);
      check("sweep_locked", 32'(locked),   1);
    end

    // Asynchronous reset in the middle of a frame
    repeat (2) frame(P, P / 2);
    hold(1'b1, 300);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    repeat (3) rst_tick();
    rst_n = 1'b1;
    model_reset();
    repeat (3) frame(P, P / 2);
    check("post_rst_duty",   32'(duty_out), 512);
    check("post_rst_locked", 32'(locked),   1);

    // Sampled glitch gives a short frame
    frame(3, 1);
    frame(P, P / 2);
    check("glitch_perr",   32'(period_err), 1);
    check("glitch_locked", 32'(locked),     0);
    frame(P, P / 2);

    // Randomized frames, including over-long ones that time out
    repeat (12) begin
      per = int'($urandom_range(1, 1100));
      hi  = int'($urandom_range(0, per));
      frame(per, hi);
    end
    hold(1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
